// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Entries carry a {pc, instruction} pair as returned by the icache.
package inst_fetch_buffer_pkg;

    localparam int unsigned IFB_ADDR_W = 32;
    localparam int unsigned IFB_INST_W = 32;

    typedef struct packed {
        logic [IFB_ADDR_W-1:0] pc;
        logic [IFB_INST_W-1:0] inst;
    } fetch_entry_t;

    // Pointer width for a power-of-two circular buffer of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/inst_fetch_buffer_storage.sv
// Entry array for the fetch buffer: two write ports at consecutive tail slots,
// two asynchronous read ports at the head and head+1 slots. Contents are not reset.
module ifb_storage
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we_0,
    input  logic [PTR_W-1:0] i_waddr_0,
    input  fetch_entry_t     i_wdata_0,
    input  logic             i_we_1,
    input  logic [PTR_W-1:0] i_waddr_1,
    input  fetch_entry_t     i_wdata_1,
    input  logic [PTR_W-1:0] i_raddr_0,
    input  logic [PTR_W-1:0] i_raddr_1,
    output fetch_entry_t     o_rdata_0,
    output fetch_entry_t     o_rdata_1
);

    fetch_entry_t r_mem [DEPTH];

    // Write addresses are always tail and tail+1, so the two ports never collide.
    always_ff @(posedge i_clk) begin
        if (i_we_0) begin
            r_mem[i_waddr_0] <= i_wdata_0;
        end
        if (i_we_1) begin
            r_mem[i_waddr_1] <= i_wdata_1;
        end
    end

    assign o_rdata_0 = r_mem[i_raddr_0];
    assign o_rdata_1 = r_mem[i_raddr_1];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Two-in/two-out in-order instruction buffer between fetch and decode.
// Show-ahead outputs, fetch pause when fewer than two slots are free, flush on redirect.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = IFB_ADDR_W,
    parameter int unsigned INST_W = IFB_INST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   inst_valid_i_1,
    input  logic                   inst_valid_i_2,
    input  logic [ADDR_W-1:0]      pc_i_1,
    input  logic [ADDR_W-1:0]      pc_i_2,
    input  logic [INST_W-1:0]      inst_i_1,
    input  logic [INST_W-1:0]      inst_i_2,
    input  logic                   decode_pause_i,
    output logic                   fetch_pause_o,
    output logic                   inst_valid_o_1,
    output logic                   inst_valid_o_2,
    output logic [ADDR_W-1:0]      pc_o_1,
    output logic [ADDR_W-1:0]      pc_o_2,
    output logic [INST_W-1:0]      inst_o_1,
    output logic [INST_W-1:0]      inst_o_2,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_pause;
    logic             w_enq_ok;
    logic [1:0]       w_n_enq;
    logic [1:0]       w_n_deq;
    logic             w_we_0;
    logic             w_we_1;
    fetch_entry_t     w_wdata_0;
    fetch_entry_t     w_wdata_1;
    fetch_entry_t     w_rdata_0;
    fetch_entry_t     w_rdata_1;
    logic [PTR_W-1:0] w_head_d;
    logic [PTR_W-1:0] w_tail_d;
    logic [CNT_W-1:0] w_count_d;

    // Registered count only: pausing never depends on same-cycle dequeue.
    assign w_pause  = r_count > CNT_W'(DEPTH - 2);
    assign w_enq_ok = ~flush & ~w_pause;

    always_comb begin
        w_n_enq   = 2'd0;
        w_we_0    = 1'b0;
        w_we_1    = 1'b0;
        w_wdata_0 = '0;
        w_wdata_1 = '0;
        if (w_enq_ok) begin
            w_n_enq = {1'b0, inst_valid_i_1} + {1'b0, inst_valid_i_2};
            w_we_0  = inst_valid_i_1 | inst_valid_i_2;
            w_we_1  = inst_valid_i_1 & inst_valid_i_2;
        end
        // A lone slot-2 entry is compacted down to the tail slot.
        w_wdata_0.pc   = inst_valid_i_1 ? pc_i_1 : pc_i_2;
        w_wdata_0.inst = inst_valid_i_1 ? inst_i_1 : inst_i_2;
        w_wdata_1.pc   = pc_i_2;
        w_wdata_1.inst = inst_i_2;
    end

    always_comb begin
        w_n_deq = 2'd0;
        if (!decode_pause_i) begin
            if (r_count >= CNT_W'(2)) begin
                w_n_deq = 2'd2;
            end else if (r_count == CNT_W'(1)) begin
                w_n_deq = 2'd1;
            end
        end
    end

    always_comb begin
        w_head_d  = r_head + PTR_W'(w_n_deq);
        w_tail_d  = r_tail + PTR_W'(w_n_enq);
        w_count_d = r_count + CNT_W'(w_n_enq) - CNT_W'(w_n_deq);
        if (flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_d;
            r_tail  <= w_tail_d;
            r_count <= w_count_d;
        end
    end

    ifb_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .i_clk     (clk),
        .i_we_0    (w_we_0),
        .i_waddr_0 (r_tail),
        .i_wdata_0 (w_wdata_0),
        .i_we_1    (w_we_1),
        .i_waddr_1 (r_tail + PTR_W'(1)),
        .i_wdata_1 (w_wdata_1),
        .i_raddr_0 (r_head),
        .i_raddr_1 (r_head + PTR_W'(1)),
        .o_rdata_0 (w_rdata_0),
        .o_rdata_1 (w_rdata_1)
    );

    assign fetch_pause_o  = w_pause;
    assign inst_valid_o_1 = (r_count >= CNT_W'(1)) & ~flush;
    assign inst_valid_o_2 = (r_count >= CNT_W'(2)) & ~flush;
    assign pc_o_1         = w_rdata_0.pc;
    assign pc_o_2         = w_rdata_1.pc;
    assign inst_o_1       = w_rdata_0.inst;
    assign inst_o_2       = w_rdata_1.inst;
    assign count_o        = r_count;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: a vector table plus hand-written
// reset/idle and sequential wrap-around streaming sequences.
module tb_inst_fetch_buffer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        v_i_1, v_i_2;
    logic [31:0] pc_i_1, pc_i_2, inst_i_1, inst_i_2;
    logic        dpause;
    logic        fpause;
    logic        v_o_1, v_o_2;
    logic [31:0] pc_o_1, pc_o_2, inst_o_1, inst_o_2;
    logic [3:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .INST_W (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .inst_valid_i_1 (v_i_1),
        .inst_valid_i_2 (v_i_2),
        .pc_i_1         (pc_i_1),
        .pc_i_2         (pc_i_2),
        .inst_i_1       (inst_i_1),
        .inst_i_2       (inst_i_2),
        .decode_pause_i (dpause),
        .fetch_pause_o  (fpause),
        .inst_valid_o_1 (v_o_1),
        .inst_valid_o_2 (v_o_2),
        .pc_o_1         (pc_o_1),
        .pc_o_2         (pc_o_2),
        .inst_o_1       (inst_o_1),
        .inst_o_2       (inst_o_2),
        .count_o        (count_o)
    );

    // Inputs applied during the cycle and outputs expected in that same cycle
    // (before the next rising edge).
    typedef struct {
        logic        flush;
        logic        v1, v2;
        logic [31:0] pc1, pc2, in1, in2;
        logic        dp;
        logic        e_v1, e_v2;
        logic [31:0] e_pc1, e_pc2, e_in1, e_in2;
        int          e_cnt;
        logic        e_pause;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, required %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic v1, input logic v2,
                                input logic [31:0] pc1, input logic [31:0] pc2,
                                input logic dp, input logic e_v1, input logic e_v2,
                                input logic [31:0] e_pc1, input logic [31:0] e_pc2,
                                input int e_cnt, input logic e_pause);
        vec_t v;
        v.flush = fl; v.v1 = v1; v.v2 = v2; v.pc1 = pc1; v.pc2 = pc2;
        v.in1 = pc1 ^ 32'h5a5a_0000; v.in2 = pc2 ^ 32'h5a5a_0000; v.dp = dp;
        v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_pc1 = e_pc1; v.e_pc2 = e_pc2;
        v.e_in1 = e_pc1 ^ 32'h5a5a_0000; v.e_in2 = e_pc2 ^ 32'h5a5a_0000;
        v.e_cnt = e_cnt; v.e_pause = e_pause;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic v1, input logic v2,
                         input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] i1, input logic [31:0] i2, input logic dp);
        flush = fl; v_i_1 = v1; v_i_2 = v2;
        pc_i_1 = p1; pc_i_2 = p2; inst_i_1 = i1; inst_i_2 = i2; dpause = dp;
    endtask

    task automatic check_outputs(input int idx, input vec_t v);
        check("valid_1", idx, {31'd0, v_o_1}, {31'd0, v.e_v1});
        check("valid_2", idx, {31'd0, v_o_2}, {31'd0, v.e_v2});
        check("count", idx, {28'd0, count_o}, v.e_cnt);
        check("fetch_pause", idx, {31'd0, fpause}, {31'd0, v.e_pause});
        if (v.e_v1) begin
            check("pc_1", idx, pc_o_1, v.e_pc1);
            check("inst_1", idx, inst_o_1, v.e_in1);
        end
        if (v.e_v2) begin
            check("pc_2", idx, pc_o_2, v.e_pc2);
            check("inst_2", idx, inst_o_2, v.e_in2);
        end
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    int          n_seen;

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
        rst = 1'b1;

        // Fill order: first two-slot enqueue, lone slot-2, full fill, flush,
        // then mixed enqueue/dequeue counts.
        vecs.push_back(mk(0, 1, 1, 32'h1c00_0000, 32'h1c00_0004, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h1c00_0000, 32'h1c00_0004, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h1c00_0000, 32'h1c00_0004, 2, 0));
        vecs.push_back(mk(0, 0, 1, 32'hdead_0000, 32'h1c00_0010, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h1c00_0010, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h1c00_0010, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h100, 32'h104, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h108, 32'h10c, 1, 1, 1, 32'h100, 32'h104, 2, 0));
        vecs.push_back(mk(0, 1, 1, 32'h110, 32'h114, 1, 1, 1, 32'h100, 32'h104, 4, 0));
        vecs.push_back(mk(0, 1, 1, 32'h118, 32'h11c, 1, 1, 1, 32'h100, 32'h104, 6, 0));
        vecs.push_back(mk(0, 1, 1, 32'h200, 32'h204, 1, 1, 1, 32'h100, 32'h104, 8, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h100, 32'h104, 8, 1));
        vecs.push_back(mk(1, 1, 1, 32'h300, 32'h304, 0, 0, 0, 0, 0, 8, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h400, 32'h404, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h400, 32'h404, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h500, 32'h504, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h508, 32'hdead_0004, 0, 1, 1, 32'h500, 32'h504, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h508, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset, then ten idle cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_outputs(100 + i, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].v1, vecs[i].v2, vecs[i].pc1, vecs[i].pc2,
                  vecs[i].in1, vecs[i].in2, vecs[i].dp);
            #1;
            check_outputs(i, vecs[i]);
        end

        // Sequential stream across the wrap point, scoreboarded by pc order.
        n_seen = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k < 20) begin
                drive(1'b0, 1'b1, 1'b1, 32'h1c00_1000 + 32'(8 * k), 32'h1c00_1004 + 32'(8 * k),
                      32'h0280_0000 + 32'(k), 32'h0280_0400 + 32'(k), 1'b0);
            end else begin
                drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
            end
            #1;
            check("stream_count", 200 + k, {28'd0, count_o},
                  (k == 0 || k == 21) ? 32'd0 : 32'd2);
            if (v_o_1) begin
                exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
                check("stream_pc_1", 200 + k, pc_o_1, exp_pc);
                n_seen++;
            end
            if (v_o_2) begin
                exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
                check("stream_pc_2", 200 + k, pc_o_2, exp_pc);
                n_seen++;
            end
            if (k < 20) begin
                exp_q.push_back(32'h1c00_1000 + 32'(8 * k));
                exp_q.push_back(32'h1c00_1004 + 32'(8 * k));
            end
        end
        check("stream_total", 300, n_seen, 40);
        check("stream_leftover", 301, exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
